iob_reg_file_dump: RTL and testbench
====================================

IOB_REG_FILE_DUMP -- requirements
Module: iob_reg_file_dump

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one register-file word and of the stream data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  request a dump; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first address read; sampled with start.
REQ-007 SHALL have port len  input  ADDR_WIDTH+1  number of words to dump, 0 to 2**ADDR_WIDTH; sampled with start.
REQ-008 SHALL have port mem_en  output  1  read strobe to the register-file port.
REQ-009 SHALL have port mem_addr  output  ADDR_WIDTH  read address to the register-file port.
REQ-010 SHALL have port mem_rdata  input  DATA_WIDTH  register-file read data, valid exactly one cycle after the mem_en/mem_addr cycle.
REQ-011 SHALL have port m_valid  output  1  stream word available.
REQ-012 SHALL have port m_ready  input  1  sink accepts the word; transfer occurs when m_valid and m_ready are both high at a rising edge.
REQ-013 SHALL have port m_data  output  DATA_WIDTH  stream word.
REQ-014 SHALL have port m_last  output  1  high with the final word of a dump.
REQ-015 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-016 SHALL have port done  output  1  one-cycle pulse at completion.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: start=1 and len>0 -> RUN; start=1 and len=0 -> DONE (no words, no mem_en); start=0 -> stay.
REQ-019 RUN: issue reads at addresses base_addr, base_addr+1, ..., modulo 2**ADDR_WIDTH (wrap from 2**ADDR_WIDTH-1 to 0); -> DRAIN once len reads have been issued.
REQ-020 A read SHALL be issued (mem_en=1) only when buffer occupancy plus in-flight reads is less than 2; mem_en=0 otherwise. No word is ever dropped or duplicated.
REQ-021 mem_rdata SHALL be written into a 2-entry output FIFO the cycle after its mem_en cycle; m_data/m_valid SHALL be driven from the FIFO head.
REQ-022 With m_ready held high, first m_valid SHALL assert in the 3rd cycle after the start-sampling edge; words then transfer one per cycle.
REQ-023 m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 m_last SHALL be high only on the len-th word.
REQ-025 DRAIN: -> DONE when the last word transfers; DONE: done=1 for one cycle, -> IDLE.
REQ-026 start while busy SHALL be ignored; base_addr/len changes after sampling SHALL have no effect.
REQ-027 len = 2**ADDR_WIDTH SHALL read every location exactly once.
REQ-028 Simultaneous FIFO push and pop with occupancy 2 SHALL not occur (guaranteed by REQ-020); push and pop in the same cycle at occupancy 1 SHALL keep occupancy 1.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE, flush the FIFO and clear counters, including mid-dump.
REQ-030 Reset values: mem_en=0, mem_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
REQ-031 After rst is released, the first start SHALL be acceptable on the next cycle.

Structure
REQ-032 State encoding localparams SHALL live in a shared package/header iob_reg_file_dump_defs; no other shared typedefs.
REQ-033 The 2-entry FIFO SHALL be a sub-module iob_skid_fifo2 (parameter DATA_WIDTH; push, pop, full, empty, occupancy).

Verification
REQ-034 Bench SHALL pair the block with iob_reg_file_dp (ADDR_WIDTH=4, DATA_WIDTH=8) preloaded with value = address.
REQ-035 base_addr=0, len=16, m_ready=1 -> m_data 0..15 on 16 consecutive cycles, first m_valid 3 cycles after start, m_last on 15, done one cycle later.
REQ-036 base_addr=14, len=4 -> m_data 14,15,0,1; m_last on 1.
REQ-037 len=0 -> done pulse, no mem_en, no m_valid.
REQ-038 base_addr=0, len=8, m_ready toggling 1,0,0,1 pattern -> m_data 0..7 in order, stable while stalled, never more than 2 outstanding reads plus buffered words.
REQ-039 rst asserted after 3 transfers of a len=16 dump -> all outputs 0 next cycle; new start base_addr=5, len=2 -> m_data 5,6.
REQ-040 start pulsed again while busy -> ignored; word count equals the original len.

Source files
------------

// File: rtl/iob_reg_file_dump_defs.sv
// State encoding shared by the register-file dump engine.
package iob_reg_file_dump_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/iob_reg_file_dp.sv
// Simple register file: one write port, one read port with one-cycle registered read data.
module iob_reg_file_dp #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/iob_skid_fifo2.sv
// Two-entry FIFO that decouples register-file read latency from stream backpressure.
module iob_skid_fifo2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            occupancy
);

  logic [1:0][DATA_WIDTH-1:0] mem;
  logic                       wptr;
  logic                       rptr;
  logic [1:0]                 cnt;
  logic                       push_ok;
  logic                       pop_ok;

  assign full      = (cnt == 2'd2);
  assign empty     = (cnt == 2'd0);
  assign occupancy = cnt;
  assign head      = mem[rptr];

  // Writes to a full FIFO or reads from an empty one are dropped rather than corrupting state.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointer, count and storage update; simultaneous push/pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem  <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop_ok) rptr <= ~rptr;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/iob_reg_file_dump.sv
// Streams a contiguous (wrapping) range of a register file out over a valid/ready port.
module iob_reg_file_dump
  import iob_reg_file_dump_defs::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [1:0]            state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rd_left;
  logic [ADDR_WIDTH:0]   tx_left;
  logic                  rd_pend;
  logic                  pop;
  logic                  credit;
  logic                  issue;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_occ;

  iob_skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend),
    .push_data (mem_rdata),
    .pop       (pop),
    .head      (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  assign m_valid  = ~fifo_empty;
  assign pop      = m_valid & m_ready;
  assign m_last   = m_valid && (tx_left == CNT_ONE);
  assign mem_addr = addr_q;

  // A new read is allowed only if buffered words (after this cycle's pop) plus the
  // read already in flight leave a free FIFO slot when its data lands. Counting the
  // pop lets a continuously ready sink take one word per cycle.
  always_comb begin
    credit = 1'b0;
    if (rd_pend) credit = fifo_empty || ((fifo_occ == 2'd1) && pop);
    else         credit = ~fifo_full || pop;
  end

  assign issue = (state == ST_RUN) && (rd_left != '0) && credit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (issue && (rd_left == CNT_ONE)) state_nx = ST_DRAIN;
      ST_DRAIN: if (pop && (tx_left == CNT_ONE)) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Control outputs decoded from state.
  always_comb begin
    mem_en = issue;
    busy   = (state == ST_RUN) || (state == ST_DRAIN);
    done   = (state == ST_DONE);
  end

  // Address, read/transfer counters and read-in-flight flag; parameters latch only in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      rd_left <= '0;
      tx_left <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= issue;
      if ((state == ST_IDLE) && start) begin
        addr_q  <= base_addr;
        rd_left <= len;
        tx_left <= len;
      end else begin
        if (issue) begin
          addr_q  <= addr_q + 1'b1;
          rd_left <= rd_left - 1'b1;
        end
        if (pop) tx_left <= tx_left - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iob_reg_file_dump.sv
// Directed bench: dump engine paired with a register file preloaded with value = address.
module tb_iob_reg_file_dump;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] base_addr = '0;
  logic [4:0] len = '0;
  logic       mem_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
  logic       done;
  logic       we = 1'b0;
  logic [3:0] waddr = '0;
  logic [7:0] wdata = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iob_reg_file_dump #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  iob_reg_file_dp #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) u_rf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (mem_en),
    .raddr (mem_addr),
    .rdata (mem_rdata)
  );

  typedef struct {
    int base;
    int len;
    bit stall;
    int exp_n;
    int exp_last;
    int repulse;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_mem_en"},   32'(mem_en),   32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_m_valid"},  32'(m_valid),  32'd0);
    chk({tag, "_m_data"},   32'(m_data),   32'd0);
    chk({tag, "_m_last"},   32'(m_last),   32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
  endtask

  // Drives start now; the next rising edge samples it. Returns just after a rising edge.
  task automatic run_dump(input int b, input int l, input bit stall, input int exp_n,
                          input int exp_last, input int repulse);
    int   issued = 0;
    int   xfers = 0;
    int   first_cyc = -1;
    int   last_cyc = -1;
    int   done_cyc = -1;
    int   last_data = -1;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    start = 1'b1; base_addr = b[3:0]; len = l[4:0];
    @(posedge clk); #1;
    start = 1'b0; base_addr = 4'hA; len = 5'd7;
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      m_ready = stall ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
      start = (cyc == repulse);
      if (start) begin base_addr = 4'd9; len = 5'd5; end
      @(negedge clk);
      chk("outstanding_le2", 32'((issued - xfers) <= 2), 32'd1);
      chk("busy", 32'(busy), 32'(xfers < l));
      chk("done", 32'(done), (l == 0) ? 32'(cyc == 1) : 32'(xfers == l));
      if (issued >= l) chk("extra_read", 32'(mem_en), 32'd0);
      if (mem_en) chk("mem_addr", 32'(mem_addr), 32'((b + issued) % 16));
      if (l == 0) chk("len0_valid", 32'(m_valid), 32'd0);
      if (pv && !pr) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(pd));
        chk("stall_last", 32'(m_last), 32'(pl));
      end
      chk("last_flag", 32'(m_last), 32'(m_valid && (xfers == l - 1)));
      if (m_valid && m_ready) begin
        chk("data", 32'(m_data), 32'((b + xfers) % 16));
        if (xfers == 0) begin
          first_cyc = cyc;
          if (!stall) chk("first_latency", 32'(cyc), 32'd3);
        end else if (!stall) begin
          chk("consecutive", 32'(cyc), 32'(first_cyc + xfers));
        end
        last_cyc  = cyc;
        last_data = int'(m_data);
      end
      if (done) done_cyc = cyc;
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      if (mem_en) issued++;
      if (m_valid && m_ready) xfers++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_seen", 32'(done_cyc > 0), 32'd1);
    chk("word_count", 32'(xfers), 32'(exp_n));
    chk("read_count", 32'(issued), 32'(exp_n));
    if (exp_n > 0) begin
      chk("last_word", 32'(last_data), 32'(exp_last));
      chk("done_after_last", 32'(done_cyc), 32'(last_cyc + 1));
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("post_mem_en", 32'(mem_en), 32'd0);
      chk("post_valid", 32'(m_valid), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    tbl[0] = '{base: 0,  len: 16, stall: 1'b0, exp_n: 16, exp_last: 15, repulse: 0};
    tbl[1] = '{base: 14, len: 4,  stall: 1'b0, exp_n: 4,  exp_last: 1,  repulse: 0};
    tbl[2] = '{base: 3,  len: 0,  stall: 1'b0, exp_n: 0,  exp_last: 0,  repulse: 0};
    tbl[3] = '{base: 0,  len: 8,  stall: 1'b1, exp_n: 8,  exp_last: 7,  repulse: 0};
    tbl[4] = '{base: 5,  len: 1,  stall: 1'b0, exp_n: 1,  exp_last: 5,  repulse: 0};
    tbl[5] = '{base: 15, len: 2,  stall: 1'b1, exp_n: 2,  exp_last: 0,  repulse: 0};
    tbl[6] = '{base: 2,  len: 3,  stall: 1'b0, exp_n: 3,  exp_last: 4,  repulse: 2};

    // Preload value = address while the dump engine is held in reset.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 4'(i); wdata = 8'(i);
    end
    @(negedge clk);
    we = 1'b0;
    chk_idle_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 7; v++)
      run_dump(tbl[v].base, tbl[v].len, tbl[v].stall, tbl[v].exp_n, tbl[v].exp_last, tbl[v].repulse);

    // Reset in the middle of a full dump, then restart on the very next cycle.
    start = 1'b1; base_addr = 4'd0; len = 5'd16; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        chk("pre_reset_data", 32'(m_data), 32'(n));
        n++;
      end
      @(posedge clk); #1;
    end
    chk("pre_reset_xfers", 32'(n), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("midreset");
    run_dump(5, 2, 1'b0, 2, 6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
